// File: rtl/relogio_pkg.sv
// Shared types and constants for the HH:MM:SS time-set controller.
// State encoding doubles as the edited-field selector.
package relogio_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        SET_H = 2'd1,
        SET_M = 2'd2,
        SET_S = 2'd3
    } ajuste_state_t;

    localparam int HEX_S0 = 0;
    localparam int HEX_S1 = 1;
    localparam int HEX_M0 = 2;
    localparam int HEX_M1 = 3;
    localparam int HEX_H0 = 4;
    localparam int HEX_H1 = 5;

    localparam logic [5:0] MASK_S = (6'b1 << HEX_S1) | (6'b1 << HEX_S0);
    localparam logic [5:0] MASK_M = (6'b1 << HEX_M1) | (6'b1 << HEX_M0);
    localparam logic [5:0] MASK_H = (6'b1 << HEX_H1) | (6'b1 << HEX_H0);

    function automatic logic [5:0] field_mask(input ajuste_state_t s);
        logic [5:0] m;
        m = '0;
        case (s)
            SET_H:   m = MASK_H;
            SET_M:   m = MASK_M;
            SET_S:   m = MASK_S;
            default: m = '0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/relogio_ajuste_ctrl_if.sv
// Button inputs and sequencing outputs of the time-set controller.
// master = controller side, slave = board/datapath side.
interface relogio_ajuste_ctrl_if;

    logic       btn_mode_n;
    logic       btn_inc_n;
    logic       tick_en;
    logic       inc_h;
    logic       inc_m;
    logic       clr_s;
    logic [1:0] sel;
    logic [5:0] blank_mask;

    modport master (
        input  btn_mode_n, btn_inc_n,
        output tick_en, inc_h, inc_m, clr_s, sel, blank_mask
    );

    modport slave (
        output btn_mode_n, btn_inc_n,
        input  tick_en, inc_h, inc_m, clr_s, sel, blank_mask
    );

endinterface

// File: rtl/relogio_debounce.sv
// Active-low key: 2-FF synchronizer, stable-count debounce, press pulse.
// Pulse leaves the block DEBOUNCE_CYC+2 cycles after the raw press.
module relogio_debounce #(
    parameter int DEBOUNCE_CYC = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYC - 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d = btn_n;
        sync2_d = sync1_q;
        level_d = level_q;
        cnt_d   = '0;
        // level_q is active-high "pressed"; any agreeing cycle restarts count
        if (~sync2_q != level_q) begin
            if (cnt_q == CNT_MAX) begin
                level_d = ~sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        press_d = level_d & ~level_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b0;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/relogio_ajuste_ctrl.sv
// Time-set sequencer: 1 Hz tick, RUN/SET_H/SET_M/SET_S mode FSM,
// per-field increment pulses and blinking digit blank mask.
module relogio_ajuste_ctrl
    import relogio_pkg::*;
#(
    parameter int CLK_HZ       = 50_000_000,
    parameter int DEBOUNCE_CYC = 1_000_000,
    parameter int BLINK_HZ     = 2
) (
    input  logic                  main_clock,
    input  logic                  main_reset,
    relogio_ajuste_ctrl_if.master bus
);

    localparam int HALF = CLK_HZ / (2 * BLINK_HZ);
    localparam int PW   = $clog2(CLK_HZ + 1);
    localparam int BW   = $clog2(HALF + 1);
    localparam logic [PW-1:0] PRE_MAX = PW'(CLK_HZ - 1);
    localparam logic [BW-1:0] BLK_MAX = BW'(HALF - 1);

    ajuste_state_t state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [BW-1:0] blink_q, blink_d;
    logic          phase_q, phase_d;
    logic          tick_q, tick_d;
    logic          inc_h_q, inc_h_d;
    logic          inc_m_q, inc_m_d;
    logic          clr_s_q, clr_s_d;
    logic [5:0]    mask_q, mask_d;
    logic          mode_evt, inc_evt;

    relogio_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_mode (
        .clk   (main_clock),
        .rst_n (main_reset),
        .btn_n (bus.btn_mode_n),
        .press (mode_evt)
    );

    relogio_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_inc (
        .clk   (main_clock),
        .rst_n (main_reset),
        .btn_n (bus.btn_inc_n),
        .press (inc_evt)
    );

    always_comb begin
        state_d = state_q;
        if (mode_evt) begin
            unique case (state_q)
                RUN:   state_d = SET_H;
                SET_H: state_d = SET_M;
                SET_M: state_d = SET_S;
                SET_S: state_d = RUN;
            endcase
        end

        // a simultaneous mode event swallows the increment
        inc_h_d = 1'b0;
        inc_m_d = 1'b0;
        clr_s_d = 1'b0;
        if (inc_evt && !mode_evt) begin
            inc_h_d = (state_q == SET_H);
            inc_m_d = (state_q == SET_M);
            clr_s_d = (state_q == SET_S);
        end

        presc_d = '0;
        tick_d  = 1'b0;
        if (state_q == RUN && state_d == RUN) begin
            if (presc_q == PRE_MAX) begin
                tick_d = 1'b1;
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end

        // state change restarts the blink so the new field starts visible
        blink_d = '0;
        phase_d = 1'b0;
        if (state_d == state_q && state_q != RUN) begin
            if (blink_q == BLK_MAX) begin
                phase_d = ~phase_q;
            end else begin
                blink_d = blink_q + 1'b1;
                phase_d = phase_q;
            end
        end
        mask_d = phase_d ? field_mask(state_d) : 6'b0;
    end

    always_ff @(posedge main_clock or negedge main_reset) begin
        if (!main_reset) begin
            state_q <= RUN;
            presc_q <= '0;
            blink_q <= '0;
            phase_q <= 1'b0;
            tick_q  <= 1'b0;
            inc_h_q <= 1'b0;
            inc_m_q <= 1'b0;
            clr_s_q <= 1'b0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            blink_q <= blink_d;
            phase_q <= phase_d;
            tick_q  <= tick_d;
            inc_h_q <= inc_h_d;
            inc_m_q <= inc_m_d;
            clr_s_q <= clr_s_d;
            mask_q  <= mask_d;
        end
    end

    assign bus.sel        = state_q;
    assign bus.tick_en    = tick_q;
    assign bus.inc_h      = inc_h_q;
    assign bus.inc_m      = inc_m_q;
    assign bus.clr_s      = clr_s_q;
    assign bus.blank_mask = mask_q;

endmodule
